lsu_mem_master: RTL and testbench

- Load/store initiator for the multicycle RV32I core's unified instruction/data memory.
- The memory has word-only write, combinational read at a[31:2], and a write strobe sampled on the clk edge.
- This block turns core LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses: read-modify-write for sub-word stores, extract plus sign/zero-extend for loads.
- Sits between the core control FSM and the memory data port.

---
 rtl/lsu_mem_master.sv | 137 +++++++++++++
 tb/tb_lsu_mem_master.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator turning RV32I byte/half/word requests into word-only memory accesses.
// Optional build macro LSU_MISALIGN_CHECK_EN turns misaligned H/HU/W accesses into errors.
module lsu_mem_master #(
  parameter int MEM_BYTES   = 512,
  parameter bit BOUND_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [31:0] MEM_LIM = 32'(MEM_BYTES);

  state_t      state;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [15:0] wd_q;
  logic        req_err;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = b;
      3'b001:  r = h;
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] off,
                                              input logic half, input logic [15:0] d);
    logic [31:0] r;
    r = w;
    if (half) r[{off[1], 4'b0000} +: 16] = d;
    else      r[{off, 3'b000} +: 8]      = d[7:0];
    return r;
  endfunction

  always_comb begin
    req_err = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_we && req_funct3[2]);
    if (BOUND_CHECK && (req_addr >= MEM_LIM)) req_err = 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
    if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)) req_err = 1'b1;
`endif
  end

  // Write strobe decoded from state so an async reset removes it at once.
  assign mem_we = (state == WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_a      <= 32'h0;
      mem_wd     <= 32'h0;
      off_q      <= 2'b00;
      f3_q       <= 3'b000;
      we_q       <= 1'b0;
      wd_q       <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q     <= req_addr[1:0];
            f3_q      <= req_funct3;
            we_q      <= req_we;
            wd_q      <= req_wdata[15:0];
            mem_a     <= {req_addr[31:2], 2'b00};
            req_ready <= 1'b0;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_we && req_funct3[1:0] == 2'b10) begin
              state  <= WRITE;
              mem_wd <= req_wdata;
            end else begin
              state <= READ;
            end
          end
        end
        // Sub-word stores merge into the fetched word; loads extract and extend.
        READ: begin
          if (we_q) begin
            mem_wd <= store_merge(mem_rd, off_q, f3_q[0], wd_q);
            state  <= WRITE;
          end else begin
            resp_rdata <= load_ext(mem_rd, off_q, f3_q);
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WRITE: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a 128-word behavioural memory.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:127];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[8:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[8:2]] <= mem_wd;

  lsu_mem_master #(.MEM_BYTES(512), .BOUND_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er, output int wecnt, output logic [31:0] wa,
                        output logic [31:0] wwd);
    lat = 0; rd = 32'hxxxxxxxx; er = 1'bx; wecnt = 0; wa = 32'h0; wwd = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_we) begin wecnt++; wa = mem_a; wwd = mem_wd; end
      if (resp_valid) begin lat = c; rd = resp_rdata; er = resp_err; break; end
    end
  endtask

  task automatic test_reset();
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready got %b want 1", req_ready); end
    tests_run++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin tests_failed++; $display("FAIL rst_resp got v=%b e=%b want 0 0", resp_valid, resp_err); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL rst_we got %b want 0", mem_we); end
    tests_run++; if (mem_a !== 32'h0 || mem_wd !== 32'h0 || resp_rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_data got a=%h wd=%h rd=%h want 0", mem_a, mem_wd, resp_rdata); end
  endtask

  task automatic test_load_word();
    int lat, wc; logic [31:0] rd, wa, wwd; logic er;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, wc, wa, wwd);
    tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL lw_lat got %0d want 2", lat); end
    tests_run++; if (rd !== 32'h87654321 || er !== 1'b0) begin tests_failed++; $display("FAIL lw_data got %h err %b want 87654321 0", rd, er); end
    tests_run++; if (wc !== 0) begin tests_failed++; $display("FAIL lw_we got %0d want 0", wc); end
    do_req(1'b0, 3'b010, 32'h1FC, 32'h0, lat, rd, er, wc, wa, wwd);
    tests_run++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin tests_failed++; $display("FAIL lw_top got %h err %b want 0badf00d 0", rd, er); end
  endtask

  task automatic test_load_subword();
    int lat, wc; logic [31:0] rd, wa, wwd; logic er;
    logic [2:0]  f3 [5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] ad [5]  = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
    logic [31:0] ex [5]  = '{32'hFFFFFF87, 32'h00000087, 32'hFFFF8765, 32'h00004321, 32'h00000021};
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, f3[i], ad[i], 32'h0, lat, rd, er, wc, wa, wwd);
      tests_run++;
      if (rd !== ex[i] || er !== 1'b0 || lat !== 2) begin
        tests_failed++;
        $display("FAIL ld_sub%0d got %h err %b lat %0d want %h 0 2", i, rd, er, lat, ex[i]);
      end
    end
  endtask

  task automatic test_misalign();
    int lat, wc; logic [31:0] rd, wa, wwd; logic er;
    do_req(1'b0, 3'b001, 32'h11, 32'h0, lat, rd, er, wc, wa, wwd);
`ifdef LSU_MISALIGN_CHECK_EN
    tests_run++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || wc !== 0) begin tests_failed++; $display("FAIL lh_mis got err %b rd %h lat %0d we %0d want 1 0 1 0", er, rd, lat, wc); end
`else
    tests_run++; if (er !== 1'b0 || rd !== 32'h00004321 || lat !== 2) begin tests_failed++; $display("FAIL lh_mis got err %b rd %h lat %0d want 0 00004321 2", er, rd, lat); end
`endif
  endtask

  task automatic test_errors();
    int lat, wc; logic [31:0] rd, wa, wwd; logic er;
    logic        we [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3 [4] = '{3'b011, 3'b010, 3'b100, 3'b110};
    logic [31:0] ad [4] = '{32'h10, 32'h200, 32'h10, 32'h10};
    for (int i = 0; i < 4; i++) begin
      do_req(we[i], f3[i], ad[i], 32'hFFFFFFFF, lat, rd, er, wc, wa, wwd);
      tests_run++;
      if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || wc !== 0) begin
        tests_failed++;
        $display("FAIL err%0d got err %b rd %h lat %0d we %0d want 1 0 1 0", i, er, rd, lat, wc);
      end
    end
    tests_run++; if (mem[4] !== 32'h87654321) begin tests_failed++; $display("FAIL err_mem got %h want 87654321", mem[4]); end
  endtask

  task automatic test_store_byte();
    int lat, wc; logic [31:0] rd, wa, wwd; logic er;
    do_req(1'b1, 3'b000, 32'h11, 32'h123456AA, lat, rd, er, wc, wa, wwd);
    tests_run++; if (wc !== 1 || wa !== 32'h10 || wwd !== 32'h8765AA21) begin tests_failed++; $display("FAIL sb_wr got n=%0d a=%h d=%h want 1 10 8765aa21", wc, wa, wwd); end
    tests_run++; if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin tests_failed++; $display("FAIL sb_resp got lat %0d err %b rd %h want 3 0 0", lat, er, rd); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, wc, wa, wwd);
    tests_run++; if (rd !== 32'h8765AA21) begin tests_failed++; $display("FAIL sb_rb got %h want 8765aa21", rd); end
  endtask

  task automatic test_store_word();
    int lat, wc; logic [31:0] rd, wa, wwd; logic er;
    do_req(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, lat, rd, er, wc, wa, wwd);
    tests_run++; if (wc !== 1 || wa !== 32'h14 || wwd !== 32'hDEADBEEF || lat !== 2) begin tests_failed++; $display("FAIL sw got n=%0d a=%h d=%h lat %0d want 1 14 deadbeef 2", wc, wa, wwd, lat); end
    do_req(1'b0, 3'b010, 32'h14, 32'h0, lat, rd, er, wc, wa, wwd);
    tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL sw_rb got %h want deadbeef", rd); end
    do_req(1'b1, 3'b001, 32'h16, 32'h9999CAFE, lat, rd, er, wc, wa, wwd);
    tests_run++; if (wc !== 1 || wwd !== 32'hCAFEBEEF || lat !== 3) begin tests_failed++; $display("FAIL sh got n=%0d d=%h lat %0d want 1 cafebeef 3", wc, wwd, lat); end
    do_req(1'b0, 3'b101, 32'h16, 32'h0, lat, rd, er, wc, wa, wwd);
    tests_run++; if (rd !== 32'h0000CAFE) begin tests_failed++; $display("FAIL lhu_rb got %h want 0000cafe", rd); end
  endtask

  task automatic test_back_to_back();
    int first, second; logic [31:0] d1, d2;
    first = 0; second = 0; d1 = 32'h0; d2 = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        if (first == 0) begin first = c; d1 = resp_rdata; end
        else begin second = c; d2 = resp_rdata; req_valid = 1'b0; break; end
      end
    end
    req_valid = 1'b0;
    tests_run++; if (first !== 2 || second !== 5) begin tests_failed++; $display("FAIL b2b_lat got %0d %0d want 2 5", first, second); end
    tests_run++; if (d1 !== 32'h8765AA21 || d2 !== 32'h8765AA21) begin tests_failed++; $display("FAIL b2b_data got %h %h want 8765aa21", d1, d2); end
  endtask

  task automatic test_reset_mid();
    logic we_at2, we_after, ready_after; int resp_seen;
    we_at2 = 1'b0; resp_seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h12; req_wdata = 32'h00001111;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    we_at2 = mem_we;
    #1 rst_n = 1'b0;
    #1 we_after = mem_we;
    tests_run++; if (we_at2 !== 1'b1) begin tests_failed++; $display("FAIL rm_we_pre got %b want 1", we_at2); end
    tests_run++; if (we_after !== 1'b0) begin tests_failed++; $display("FAIL rm_we_async got %b want 0", we_after); end
    @(negedge clk);
    rst_n = 1'b1;
    ready_after = req_ready;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (resp_valid) resp_seen++; end
    tests_run++; if (ready_after !== 1'b1 || resp_seen !== 0) begin tests_failed++; $display("FAIL rm_state got ready %b resp %0d want 1 0", ready_after, resp_seen); end
    tests_run++; if (mem[4] !== 32'h8765AA21) begin tests_failed++; $display("FAIL rm_mem got %h want 8765aa21", mem[4]); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[4]   = 32'h87654321;
    mem[127] = 32'h0BADF00D;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_load_word();
    test_load_subword();
    test_misalign();
    test_errors();
    test_store_byte();
    test_store_word();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
